mips32_fetch_queue: RTL and testbench



---
 rtl/mips32_pkg.sv | 23 ++
 rtl/mips32_sync_fifo.sv | 78 +++++++
 rtl/mips32_fetch_queue.sv | 146 ++++++++++++++
 tb/tb_mips32_fetch_queue.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: instruction width, opcodes, fetch FSM encoding.
package mips32_pkg;

   localparam int IW = 32;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_HLT   = 6'b111111;

   // IDLE: nothing outstanding; WAIT: outstanding, response kept;
   // DROP: outstanding, response discarded (stale after a redirect).
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/mips32_sync_fifo.sv
// Synchronous FIFO with a registered head entry and occupancy count.
module mips32_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64,
   localparam int PW   = $clog2(DEPTH),
   localparam int LW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   input  logic          flush,
   output logic [W-1:0]  head,
   output logic          head_vld,
   output logic [LW-1:0] level
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, rd_nx;
   logic [LW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  head_q, head_d;
   logic          vld_q, vld_d;
   logic          do_pop;

   // Next pointers/count; head register tracks what the next head entry will be
   always_comb begin
      rd_d   = rd_q;
      wr_d   = wr_q;
      cnt_d  = cnt_q;
      head_d = head_q;
      do_pop = pop && (cnt_q != '0);
      rd_nx  = rd_q + PW'(1);
      if (flush) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (push)   wr_d = wr_q + PW'(1);
         if (do_pop) rd_d = rd_nx;
         cnt_d = cnt_q + LW'(push) - LW'(do_pop);
         if (do_pop) begin
            if (cnt_q >= LW'(2)) head_d = mem_q[rd_nx];
            else if (push)       head_d = din;
         end else if (cnt_q == '0 && push) begin
            head_d = din;
         end
      end
      vld_d = (cnt_d != '0);
   end

   // Storage array; written only on an unflushed push
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_q] <= din;
   end

   // Pointer, count and head registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         head_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
         vld_q  <= vld_d;
      end
   end

   assign head     = head_q;
   assign head_vld = vld_q;
   assign level    = cnt_q;

endmodule

// File: rtl/mips32_fetch_queue.sv
// Instruction prefetch: issues imem reads, queues {npc, ir}, handles redirect/halt.
module mips32_fetch_queue
   import mips32_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter int          AW       = 10,
   parameter logic [31:0] RESET_PC = 32'd0,
   localparam int         LW       = $clog2(DEPTH) + 1
) (
   input  logic          clk1,
   input  logic          rst,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [IW-1:0] imem_rdata,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc,
   input  logic          halt,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] out_ir,
   output logic [31:0]   out_npc,
   output logic [LW-1:0] level
);

   localparam logic [LW:0] DEPTH_X = (LW+1)'(DEPTH);

   fetch_state_t  state_q, state_d;
   logic [31:0]   pc_q, pc_d, pc_inc;
   logic [AW-1:0] addr_q, addr_d;
   logic          req_q, req_d;
   logic          push, flush, pend, issue, issue_bb;
   logic [LW:0]   lvl_x;
   logic [63:0]   head;

   // Issue gating: a slot is reserved for the outstanding request, so a push never hits a full FIFO
   always_comb begin
      pc_inc   = pc_q + 32'd1;
      pend     = (state_q != IDLE);
      lvl_x    = {1'b0, level};
      issue    = !halt && ((lvl_x + (LW+1)'(pend)) < DEPTH_X);
      issue_bb = !halt && ((lvl_x + (LW+1)'(1)) < DEPTH_X);
   end

   // Fetch FSM next state, pc and request register values
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      req_d   = req_q;
      push    = 1'b0;
      flush   = 1'b0;
      case (state_q)
         IDLE: begin
            if (redirect) begin
               // Queue is empty after the flush, so only halt can hold off the refetch
               flush = 1'b1;
               pc_d  = redirect_pc;
               if (!halt) begin
                  state_d = WAIT;
                  req_d   = 1'b1;
                  addr_d  = redirect_pc[AW-1:0];
               end
            end else if (issue) begin
               state_d = WAIT;
               req_d   = 1'b1;
               addr_d  = pc_q[AW-1:0];
            end
         end
         WAIT: begin
            if (imem_ack && redirect) begin
               // Returned word is on the wrong path; refetch immediately
               flush = 1'b1;
               pc_d  = redirect_pc;
               if (!halt) begin
                  addr_d = redirect_pc[AW-1:0];
               end else begin
                  state_d = IDLE;
                  req_d   = 1'b0;
               end
            end else if (imem_ack) begin
               push = 1'b1;
               pc_d = pc_inc;
               if (issue_bb) begin
                  addr_d = pc_inc[AW-1:0];
               end else begin
                  state_d = IDLE;
                  req_d   = 1'b0;
               end
            end else if (redirect) begin
               // Request is still in flight: keep address stable, discard its data later
               flush   = 1'b1;
               pc_d    = redirect_pc;
               state_d = DROP;
            end
         end
         DROP: begin
            if (redirect) begin
               flush = 1'b1;
               pc_d  = redirect_pc;
            end
            if (imem_ack) begin
               state_d = IDLE;
               req_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // FSM, pc and memory-request registers
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC[AW-1:0];
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
      end
   end

   mips32_sync_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
      .clk      (clk1),
      .rst      (rst),
      .push     (push),
      .din      ({pc_inc, imem_rdata}),
      .pop      (out_valid && out_ready),
      .flush    (flush),
      .head     (head),
      .head_vld (out_valid),
      .level    (level)
   );

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign out_ir    = head[31:0];
   assign out_npc   = head[63:32];

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed bench for mips32_fetch_queue; memory word at address A is 0x28010000 + A.
module tb_mips32_fetch_queue;

   logic        clk1 = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        halt = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_ir;
   logic [31:0] out_npc;
   logic [2:0]  level;

   logic        auto_ack = 1'b0;
   logic        man_ack = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk1 = ~clk1;

   assign imem_ack   = man_ack | (auto_ack & imem_req);
   assign imem_rdata = 32'h2801_0000 + 32'(imem_addr);

   mips32_fetch_queue dut (
      .clk1        (clk1),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_ir      (out_ir),
      .out_npc     (out_npc),
      .level       (level)
   );

   task automatic do_reset();
      rst = 1'b1;
      redirect = 1'b0;
      man_ack = 1'b0;
      @(negedge clk1);
      @(negedge clk1);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      halt = 1'b1;
      rst = 1'b1;
      @(negedge clk1);
      @(negedge clk1);
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %0b want 0", imem_req); end
      n_cmp++; if (imem_addr !== 10'd0) begin n_bad++; $display("FAIL rst_addr got %0h want 0", imem_addr); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %0b want 0", out_valid); end
      n_cmp++; if (out_ir !== 32'd0) begin n_bad++; $display("FAIL rst_ir got %0h want 0", out_ir); end
      n_cmp++; if (out_npc !== 32'd0) begin n_bad++; $display("FAIL rst_npc got %0h want 0", out_npc); end
      n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL rst_level got %0d want 0", level); end
      halt = 1'b0;
   endtask

   task automatic test_throughput();
      auto_ack = 1'b1; out_ready = 1'b1; halt = 1'b0;
      do_reset();
      @(negedge clk1);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin n_bad++; $display("FAIL thr_first_req got req=%0b addr=%0h want 1/0", imem_req, imem_addr); end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk1);
         n_cmp++; if (out_valid !== 1'b1 || out_ir !== 32'h2801_0000 + 32'(k)) begin n_bad++; $display("FAIL thr_ir k=%0d got v=%0b ir=%0h want 1/%0h", k, out_valid, out_ir, 32'h2801_0000 + 32'(k)); end
         n_cmp++; if (out_npc !== 32'(k + 1)) begin n_bad++; $display("FAIL thr_npc k=%0d got %0h want %0h", k, out_npc, k + 1); end
         n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL thr_req k=%0d got %0b want 1", k, imem_req); end
      end
      auto_ack = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int reqs;
      auto_ack = 1'b1; out_ready = 1'b0; halt = 1'b0;
      do_reset();
      repeat (7) @(negedge clk1);
      n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL bp_full_level got %0d want 4", level); end
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_full_req got %0b want 0", imem_req); end
      n_cmp++; if (out_ir !== 32'h2801_0000) begin n_bad++; $display("FAIL bp_head got %0h want 28010000", out_ir); end
      out_ready = 1'b1;
      @(negedge clk1);
      out_ready = 1'b0;
      n_cmp++; if (level !== 3'd3 || out_ir !== 32'h2801_0001) begin n_bad++; $display("FAIL bp_pop got lvl=%0d ir=%0h want 3/28010001", level, out_ir); end
      reqs = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk1);
         if (imem_req === 1'b1) begin
            reqs++;
            n_cmp++; if (imem_addr !== 10'd4) begin n_bad++; $display("FAIL bp_req_addr got %0h want 4", imem_addr); end
         end
      end
      n_cmp++; if (reqs != 1) begin n_bad++; $display("FAIL bp_req_count got %0d want 1", reqs); end
      n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL bp_refill_level got %0d want 4", level); end
      auto_ack = 1'b0;
   endtask

   task automatic test_redirect_delayed();
      auto_ack = 1'b0; out_ready = 1'b1; halt = 1'b0;
      do_reset();
      @(negedge clk1);
      redirect = 1'b1; redirect_pc = 32'h20;
      @(negedge clk1);
      redirect = 1'b0;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin n_bad++; $display("FAIL rd_hold got req=%0b addr=%0h want 1/0", imem_req, imem_addr); end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk1);
         n_cmp++; if (out_valid !== 1'b0 || imem_addr !== 10'd0) begin n_bad++; $display("FAIL rd_wait k=%0d got v=%0b addr=%0h want 0/0", k, out_valid, imem_addr); end
      end
      man_ack = 1'b1;
      @(negedge clk1);
      man_ack = 1'b0;
      n_cmp++; if (out_valid !== 1'b0 || imem_req !== 1'b0) begin n_bad++; $display("FAIL rd_drop got v=%0b req=%0b want 0/0", out_valid, imem_req); end
      @(negedge clk1);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 10'h20) begin n_bad++; $display("FAIL rd_newreq got req=%0b addr=%0h want 1/20", imem_req, imem_addr); end
      man_ack = 1'b1;
      @(negedge clk1);
      man_ack = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || out_ir !== 32'h2801_0020 || out_npc !== 32'h21) begin n_bad++; $display("FAIL rd_first got v=%0b ir=%0h npc=%0h want 1/28010020/21", out_valid, out_ir, out_npc); end
   endtask

   task automatic test_redirect_ack();
      auto_ack = 1'b1; out_ready = 1'b0; halt = 1'b0;
      do_reset();
      repeat (3) @(negedge clk1);
      n_cmp++; if (level !== 3'd2) begin n_bad++; $display("FAIL ra_pre_level got %0d want 2", level); end
      redirect = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1;
      @(negedge clk1);
      redirect = 1'b0; out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0 || level !== 3'd0) begin n_bad++; $display("FAIL ra_flush got v=%0b lvl=%0d want 0/0", out_valid, level); end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 10'h100) begin n_bad++; $display("FAIL ra_req got req=%0b addr=%0h want 1/100", imem_req, imem_addr); end
      @(negedge clk1);
      n_cmp++; if (out_valid !== 1'b1 || out_ir !== 32'h2801_0100 || out_npc !== 32'h101) begin n_bad++; $display("FAIL ra_first got v=%0b ir=%0h npc=%0h want 1/28010100/101", out_valid, out_ir, out_npc); end
      auto_ack = 1'b0;
   endtask

   task automatic test_halt();
      int reqs;
      auto_ack = 1'b0; out_ready = 1'b1; halt = 1'b0;
      do_reset();
      @(negedge clk1);
      halt = 1'b1;
      @(negedge clk1);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin n_bad++; $display("FAIL ht_pending got req=%0b addr=%0h want 1/0", imem_req, imem_addr); end
      man_ack = 1'b1;
      @(negedge clk1);
      man_ack = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || out_ir !== 32'h2801_0000 || out_npc !== 32'd1) begin n_bad++; $display("FAIL ht_word got v=%0b ir=%0h npc=%0h want 1/28010000/1", out_valid, out_ir, out_npc); end
      reqs = 0;
      for (int k = 0; k < 4; k++) begin
         if (imem_req === 1'b1) reqs++;
         @(negedge clk1);
      end
      n_cmp++; if (reqs != 0) begin n_bad++; $display("FAIL ht_no_req got %0d want 0", reqs); end
      halt = 1'b0;
      @(negedge clk1);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 10'd1) begin n_bad++; $display("FAIL ht_resume got req=%0b addr=%0h want 1/1", imem_req, imem_addr); end
   endtask

   task automatic test_wrap_and_async_reset();
      auto_ack = 1'b0; out_ready = 1'b1; halt = 1'b0;
      do_reset();
      @(negedge clk1);
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; man_ack = 1'b1;
      @(negedge clk1);
      redirect = 1'b0; man_ack = 1'b0;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 10'h3FF) begin n_bad++; $display("FAIL wr_req got req=%0b addr=%0h want 1/3ff", imem_req, imem_addr); end
      man_ack = 1'b1;
      @(negedge clk1);
      man_ack = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || out_npc !== 32'd0 || out_ir !== 32'h2801_03FF) begin n_bad++; $display("FAIL wr_npc got v=%0b npc=%0h ir=%0h want 1/0/280103ff", out_valid, out_npc, out_ir); end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin n_bad++; $display("FAIL wr_next_addr got req=%0b addr=%0h want 1/0", imem_req, imem_addr); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 10'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_ctrl got req=%0b addr=%0h v=%0b want 0/0/0", imem_req, imem_addr, out_valid); end
      n_cmp++; if (out_ir !== 32'd0 || out_npc !== 32'd0 || level !== 3'd0) begin n_bad++; $display("FAIL ar_data got ir=%0h npc=%0h lvl=%0d want 0/0/0", out_ir, out_npc, level); end
      @(negedge clk1);
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_throughput();
      test_backpressure();
      test_redirect_delayed();
      test_redirect_ack();
      test_halt();
      test_wrap_and_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
